// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - register file / scoreboard bus between issue, writeback and the regfile
interface regfile_sb_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  localparam int NREGS = 2 ** ADDR_W;

  // writeback side
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [XLEN-1:0]          wdata;

  // decode / issue side
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*XLEN-1:0]   rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     issue;
  logic [ADDR_W-1:0]        issue_rd;
  logic                     flush;

  // debug / flush visibility
  logic [NREGS-1:0]         busy_vec;

  modport master (
    output we, waddr, wdata, raddr, issue, issue_rd, flush,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  we, waddr, wdata, raddr, issue, issue_rd, flush,
    output rdata, rbusy, busy_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with per-register busy scoreboard
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic             wr_ok;

  // Per-port read results before the reset gate.
  logic [XLEN-1:0]  rd_val  [NUM_RD];
  logic             rd_busy [NUM_RD];

  // Writes to x0 are dropped when it is hardwired, so regs[0] stays zero.
  assign wr_ok = bus.we && !(ZERO_REG && (bus.waddr == '0));

  // Register storage: asynchronous clear, one synchronous write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // One-hot decode of the issuing destination and the retiring writeback.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (bus.issue) begin
      set_vec[bus.issue_rd] = 1'b1;
    end
    if (bus.we) begin
      clr_vec[bus.waddr] = 1'b1;
    end
  end

  // Next busy state: flush beats everything, a new producer beats a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      busy_d = set_vec | (busy_q & ~clr_vec);
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  // Busy flops, cleared asynchronously with the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;

  // Independent combinational read ports; x0 first, then same-cycle forward, then storage.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              fwd;

    assign ra      = bus.raddr[k*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_REG && (ra == '0);
    assign fwd     = BYPASS && bus.we && (bus.waddr == ra);

    assign rd_val[k]  = is_zero ? '0 : (fwd ? bus.wdata : regs[ra]);
    // A forwarded writeback is the retiring producer, so the operand is already available.
    assign rd_busy[k] = !is_zero && busy_q[ra] && !fwd;
  end

  // Pack the read ports; reset forces them to zero so forwarded wdata cannot leak out.
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    if (!reset) begin
      for (int k = 0; k < NUM_RD; k++) begin
        bus.rdata[k*XLEN +: XLEN] = rd_val[k];
        bus.rbusy[k]              = rd_busy[k];
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb, default and swept parameters
module tb_regfile_sb;
  logic clk;
  logic reset;

  int n_checks;
  int n_pass;

  regfile_sb_if #(.XLEN(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
  regfile_sb_if #(.XLEN(64), .ADDR_W(4), .NUM_RD(3)) bus_b ();

  regfile_sb #(
    .XLEN(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  regfile_sb #(
    .XLEN(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) u_dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.we = 1'b0; bus_a.waddr = '0; bus_a.wdata = '0; bus_a.raddr = '0;
    bus_a.issue = 1'b0; bus_a.issue_rd = '0; bus_a.flush = 1'b0;
  endtask

  task automatic idle_b();
    bus_b.we = 1'b0; bus_b.waddr = '0; bus_b.wdata = '0; bus_b.raddr = '0;
    bus_b.issue = 1'b0; bus_b.issue_rd = '0; bus_b.flush = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle_a();
    idle_b();
    reset = 1'b1;
    #2;
    check("a_rst_rdata", bus_a.rdata, 64'h0);
    check("a_rst_busy", bus_a.busy_vec, 64'h0);
    for (int k = 0; k < 3; k++) begin
      check("b_rst_rdata", bus_b.rdata[64*k +: 64], 64'h0);
    end
    check("b_rst_busy", bus_b.busy_vec, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // ---------------- instance A: XLEN 32, 32 regs, 2 ports, x0 hardwired, bypass on
    // reset clear mid-operation
    bus_a.we = 1'b1; bus_a.waddr = 5'd5; bus_a.wdata = 32'hDEADBEEF;
    bus_a.issue = 1'b1; bus_a.issue_rd = 5'd6;
    step();
    idle_a();
    bus_a.raddr = {5'd6, 5'd5};
    #1;
    check("a_t1_x5", bus_a.rdata[31:0], 64'hDEADBEEF);
    check("a_t1_busy6", bus_a.busy_vec[6], 64'h1);
    check("a_t1_rbusy1", bus_a.rbusy, 64'h2);
    reset = 1'b1;
    #1;
    check("a_t1_rst_x5", bus_a.rdata[31:0], 64'h0);
    check("a_t1_rst_busy", bus_a.busy_vec, 64'h0);
    check("a_t1_rst_rbusy", bus_a.rbusy, 64'h0);
    #1;
    reset = 1'b0;
    bus_a.we = 1'b1; bus_a.waddr = 5'd5; bus_a.wdata = 32'h11;
    step();
    idle_a();
    bus_a.raddr = {5'd0, 5'd5};
    #1;
    check("a_t1_post_rst_wr", bus_a.rdata[31:0], 64'h11);

    // x0 ignores writes and never becomes busy
    bus_a.we = 1'b1; bus_a.waddr = 5'd0; bus_a.wdata = 32'h1234;
    bus_a.issue = 1'b1; bus_a.issue_rd = 5'd0; bus_a.raddr = {5'd0, 5'd0};
    #1;
    check("a_t2_x0_comb", bus_a.rdata, 64'h0);
    check("a_t2_rbusy_comb", bus_a.rbusy, 64'h0);
    step();
    idle_a();
    bus_a.raddr = {5'd0, 5'd0};
    #1;
    check("a_t2_x0", bus_a.rdata, 64'h0);
    check("a_t2_busy0", bus_a.busy_vec[0], 64'h0);
    check("a_t2_rbusy", bus_a.rbusy, 64'h0);

    // same-cycle bypass on both ports
    bus_a.we = 1'b1; bus_a.waddr = 5'd7; bus_a.wdata = 32'h1111;
    step();
    bus_a.wdata = 32'hA5A5A5A5; bus_a.raddr = {5'd7, 5'd7};
    #1;
    check("a_t3_bypass", bus_a.rdata, 64'hA5A5A5A5_A5A5A5A5);
    step();
    idle_a();
    bus_a.raddr = {5'd7, 5'd7};
    #1;
    check("a_t3_stored", bus_a.rdata, 64'hA5A5A5A5_A5A5A5A5);

    // scoreboard life cycle on x3
    bus_a.issue = 1'b1; bus_a.issue_rd = 5'd3; bus_a.raddr = {5'd0, 5'd3};
    step();
    bus_a.issue = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check("a_t4_rbusy_c", bus_a.rbusy[0], 64'h1);
      step();
    end
    #1;
    check("a_t4_rbusy_c4", bus_a.rbusy[0], 64'h1);
    bus_a.we = 1'b1; bus_a.waddr = 5'd3; bus_a.wdata = 32'h33;
    #1;
    check("a_t4_rbusy_wb", bus_a.rbusy[0], 64'h0);
    check("a_t4_vec_wb", bus_a.busy_vec[3], 64'h1);
    step();
    idle_a();
    bus_a.raddr = {5'd0, 5'd3};
    #1;
    check("a_t4_vec_after", bus_a.busy_vec[3], 64'h0);
    check("a_t4_data", bus_a.rdata[31:0], 64'h33);

    // set/clear collision on x9
    bus_a.issue = 1'b1; bus_a.issue_rd = 5'd9;
    step();
    bus_a.we = 1'b1; bus_a.waddr = 5'd9; bus_a.wdata = 32'h99;
    step();
    idle_a();
    bus_a.raddr = {5'd0, 5'd9};
    #1;
    check("a_t5_busy9", bus_a.busy_vec[9], 64'h1);
    check("a_t5_data", bus_a.rdata[31:0], 64'h99);
    check("a_t5_rbusy", bus_a.rbusy[0], 64'h1);
    bus_a.we = 1'b1; bus_a.waddr = 5'd9; bus_a.wdata = 32'h99;
    step();
    idle_a();
    #1;
    check("a_t5_cleared", bus_a.busy_vec, 64'h0);

    // flush with a concurrent write and issue
    bus_a.issue = 1'b1; bus_a.issue_rd = 5'd1;
    step();
    bus_a.issue_rd = 5'd2;
    step();
    bus_a.issue_rd = 5'd31;
    step();
    idle_a();
    #1;
    check("a_t6_busy_set", bus_a.busy_vec, 64'h80000006);
    bus_a.flush = 1'b1; bus_a.we = 1'b1; bus_a.waddr = 5'd2; bus_a.wdata = 32'h55;
    bus_a.issue = 1'b1; bus_a.issue_rd = 5'd4;
    step();
    idle_a();
    bus_a.raddr = {5'd0, 5'd2};
    #1;
    check("a_t6_flushed", bus_a.busy_vec, 64'h0);
    check("a_t6_x2", bus_a.rdata[31:0], 64'h55);

    // ---------------- instance B: XLEN 64, 16 regs, 3 ports, x0 ordinary, bypass off
    // reset clear mid-operation
    bus_b.we = 1'b1; bus_b.waddr = 4'd5; bus_b.wdata = 64'hDEADBEEF_CAFEF00D;
    bus_b.issue = 1'b1; bus_b.issue_rd = 4'd6;
    step();
    idle_b();
    bus_b.raddr = {4'd5, 4'd6, 4'd5};
    #1;
    check("b_t1_x5", bus_b.rdata[128 +: 64], 64'hDEADBEEF_CAFEF00D);
    check("b_t1_busy6", bus_b.busy_vec[6], 64'h1);
    check("b_t1_rbusy", bus_b.rbusy, 64'h2);
    reset = 1'b1;
    #1;
    check("b_t1_rst_x5", bus_b.rdata[128 +: 64], 64'h0);
    check("b_t1_rst_busy", bus_b.busy_vec, 64'h0);
    check("b_t1_rst_rbusy", bus_b.rbusy, 64'h0);
    #1;
    reset = 1'b0;

    // x0 is an ordinary register
    bus_b.we = 1'b1; bus_b.waddr = 4'd0; bus_b.wdata = 64'h1234;
    bus_b.issue = 1'b1; bus_b.issue_rd = 4'd0; bus_b.raddr = '0;
    #1;
    check("b_t2_x0_old", bus_b.rdata[0 +: 64], 64'h0);
    step();
    idle_b();
    #1;
    check("b_t2_x0", bus_b.rdata[0 +: 64], 64'h1234);
    check("b_t2_busy0", bus_b.busy_vec[0], 64'h1);
    check("b_t2_rbusy", bus_b.rbusy, 64'h7);
    bus_b.we = 1'b1; bus_b.waddr = 4'd0; bus_b.wdata = 64'h1234;
    step();
    idle_b();

    // no bypass: old value first, new value the cycle after
    bus_b.we = 1'b1; bus_b.waddr = 4'd7; bus_b.wdata = 64'h1111;
    step();
    bus_b.wdata = 64'hA5A5A5A5; bus_b.raddr = {4'd7, 4'd7, 4'd7};
    #1;
    check("b_t3_old0", bus_b.rdata[0 +: 64], 64'h1111);
    check("b_t3_old1", bus_b.rdata[64 +: 64], 64'h1111);
    step();
    idle_b();
    bus_b.raddr = {4'd7, 4'd7, 4'd7};
    #1;
    check("b_t3_new2", bus_b.rdata[128 +: 64], 64'hA5A5A5A5);
    check("b_t3_new0", bus_b.rdata[0 +: 64], 64'hA5A5A5A5);

    // scoreboard life cycle on x3 without the bypass relief
    bus_b.issue = 1'b1; bus_b.issue_rd = 4'd3; bus_b.raddr = {4'd0, 4'd0, 4'd3};
    step();
    bus_b.issue = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check("b_t4_rbusy_c", bus_b.rbusy[0], 64'h1);
      step();
    end
    bus_b.we = 1'b1; bus_b.waddr = 4'd3; bus_b.wdata = 64'h33;
    #1;
    check("b_t4_rbusy_wb", bus_b.rbusy[0], 64'h1);
    step();
    idle_b();
    bus_b.raddr = {4'd0, 4'd0, 4'd3};
    #1;
    check("b_t4_vec_after", bus_b.busy_vec[3], 64'h0);
    check("b_t4_rbusy_after", bus_b.rbusy[0], 64'h0);
    check("b_t4_data", bus_b.rdata[0 +: 64], 64'h33);

    // set/clear collision on x9
    bus_b.issue = 1'b1; bus_b.issue_rd = 4'd9;
    step();
    bus_b.we = 1'b1; bus_b.waddr = 4'd9; bus_b.wdata = 64'h99;
    step();
    idle_b();
    bus_b.raddr = {4'd0, 4'd0, 4'd9};
    #1;
    check("b_t5_busy9", bus_b.busy_vec[9], 64'h1);
    check("b_t5_data", bus_b.rdata[0 +: 64], 64'h99);
    bus_b.we = 1'b1; bus_b.waddr = 4'd9; bus_b.wdata = 64'h99;
    step();
    idle_b();

    // flush with a concurrent write and issue
    bus_b.issue = 1'b1; bus_b.issue_rd = 4'd1;
    step();
    bus_b.issue_rd = 4'd2;
    step();
    bus_b.issue_rd = 4'd15;
    step();
    idle_b();
    #1;
    check("b_t6_busy_set", bus_b.busy_vec, 64'h8006);
    bus_b.flush = 1'b1; bus_b.we = 1'b1; bus_b.waddr = 4'd2; bus_b.wdata = 64'h55;
    bus_b.issue = 1'b1; bus_b.issue_rd = 4'd4;
    step();
    idle_b();
    bus_b.raddr = {4'd0, 4'd0, 4'd2};
    #1;
    check("b_t6_flushed", bus_b.busy_vec, 64'h0);
    check("b_t6_x2", bus_b.rdata[0 +: 64], 64'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
